itr_ctrl: RTL and testbench
===========================

# itr_ctrl

Four-line interrupt controller for the 8-bit pipelined processor. It synchronises and edge-detects external interrupt requests, latches them into a pending register and gates them with a software mask. It presents the highest-priority eligible request to the pipeline as a pending flag plus vector, then saves PC and ACC into shadow registers when the core accepts the interrupt. It sequences the non-nesting service/return handshake with the control unit.

## Interface
- VEC_BASE, 8'hF0, base of the vector table; level n vectors to VEC_BASE + 4*n (mod 256)
- g_clk  in  1  system clock, all state on rising edge
- g_clr  in  1  reset, asynchronous, active-high
- irq_in  in  4  raw interrupt lines, asynchronous, rising-edge sensitive; bit 0 highest priority
- mask_we  in  1  load mask_reg from mask_din
- mask_din  in  4  new mask, 1 = enabled
- clr_we  in  1  software clear of pending bits
- clr_din  in  4  bits of itr_reg to clear
- itr_take  in  1  core at instruction boundary accepts the offered interrupt
- pc_in  in  8  PC to save on take
- acc_in  in  8  ACC to save on take
- rti  in  1  return-from-interrupt executed
- itr_pend  out  1  interrupt offered to core
- itr_vec  out  8  vector of offered level, valid while itr_pend = 1
- active_lvl  out  2  level currently offered or in service
- in_service  out  1  handler running
- restore  out  1  one-cycle pulse; core reloads PC/ACC from pc_s_out/acc_s_out
- itr_reg  out  4  pending register
- mask_reg  out  4  mask register
- pc_s_out  out  8  saved PC
- acc_s_out  out  8  saved ACC

## Operation
- Each irq_in bit passes through two synchroniser flops (s1, s2) and a history flop (prev). An edge is s2 & ~prev.
- Pending update per bit, in priority order: edge sets the bit; else a take clears the bit at the taken level; else clr_we & clr_din clears the bit. An edge wins over any clear in the same cycle, so no event is lost.
- eligible = itr_reg & mask_reg. sel_lvl = lowest set bit index of eligible.
- FSM states:
  - IDLE: if eligible != 0, go to PEND.
  - PEND: itr_pend = 1, itr_vec = VEC_BASE + {sel_lvl, 2'b00}, active_lvl = sel_lvl, recomputed every cycle.
    - eligible == 0 (cleared or masked): go to IDLE, with no take.
    - itr_take: capture pc_in/acc_in into the shadow registers, latch active_lvl, clear that pending bit, go to SERVICE.
  - SERVICE: in_service = 1; itr_pend = 0 regardless of new requests (no nesting). rti goes to RETURN.
  - RETURN: restore = 1 for exactly one cycle, then IDLE. Any pending eligible request re-enters PEND on the following edge.
- itr_take outside PEND and rti outside SERVICE are ignored.
- mask_we and clr_we are accepted in every state. They do not abort a service in progress.
- pc_s_out/acc_s_out hold their values until the next take.

## Timing
- Reset values of every output are 0: itr_pend, itr_vec, active_lvl, in_service, restore, itr_reg, mask_reg (all disabled), pc_s_out, acc_s_out. Synchroniser and prev flops are also 0. State is IDLE.
- Reset mid-service abandons the service; no restore pulse is issued.
- A line already high at reset release produces one edge, which is latched but masked by default.
- irq_in rising before edge k: s1 at k, s2 at k+1, itr_reg bit set at k+2. If enabled, PEND (itr_pend = 1) at k+3.
- mask_we at edge m with an already-pending bit: PEND at m+1.
- itr_take sampled at edge t: in_service = 1 and shadows valid after t; itr_pend low after t.
- rti at edge r: restore high for the cycle after r, IDLE after r+1. Minimum gap from rti to the next itr_pend is 2 cycles.
- itr_vec and active_lvl are registered from state and sel_lvl. They may change level inside PEND when a higher-priority request arrives before take.

## Test plan
- Single request: mask=4'b0100, pulse irq_in[2]. Response: itr_reg=4'b0100 three edges later, itr_pend=1, itr_vec=8'hF8. Take with pc_in=8'h3A, acc_in=8'h0A: pc_s_out=3A, acc_s_out=0A, itr_reg=0, in_service=1.
- Priority: mask=4'hF, irq_in[3] and irq_in[1] rise together. Response: itr_vec=8'hF4 first. After take then rti, one restore pulse, then itr_pend returns with itr_vec=8'hFC.
- Preemption before take: irq_in[2] pending and offered (vector F8), then irq_in[0] rises. Response: itr_vec becomes 8'hF0 with itr_pend held high; the take services level 0 and bit 2 stays pending.
- Masking and clear: irq_in[1] pending, mask=0. Response: itr_pend stays 0. Set mask[1] then write clr_din=4'b0010 while in PEND: itr_pend drops next cycle, itr_reg=0.
- Simultaneous edge and clear on bit 3: response is itr_reg[3]=1. Request arriving during SERVICE: latched, itr_pend stays 0 until after the restore pulse.
- Reset mid-service: assert g_clr asynchronously between edges while in_service=1. Response: all outputs 0 immediately, no restore pulse, and an ignored rti after reset has no effect.

Source files
------------

// File: rtl/itr_ctrl.sv
// itr_ctrl: four-line interrupt controller for the 8-bit pipelined core.
//
// Raw interrupt lines are synchronised and edge-detected, then latched into a
// pending register. A software mask gates them. The highest-priority eligible
// level (bit 0 highest) is offered to the core as itr_pend plus a vector.
// On take, PC/ACC are saved into shadow registers and the handler runs without
// nesting until rti, which produces a one-cycle restore pulse.
//
// Ports:
//   g_clk, g_clr             clock (rising edge), asynchronous active-high reset
//   irq_in[3:0]              raw asynchronous interrupt lines, rising-edge sensitive
//   mask_we, mask_din[3:0]   load mask register (1 = enabled)
//   clr_we, clr_din[3:0]     software clear of pending bits
//   itr_take                 core accepts the offered interrupt
//   pc_in[7:0], acc_in[7:0]  state saved on take
//   rti                      return-from-interrupt executed
//   itr_pend, itr_vec[7:0]   interrupt offered and its vector
//   active_lvl[1:0]          level offered or in service
//   in_service, restore      handler running / one-cycle PC-ACC reload pulse
//   itr_reg[3:0], mask_reg[3:0], pc_s_out[7:0], acc_s_out[7:0]  visible state
module itr_ctrl #(
    parameter logic [7:0] VEC_BASE = 8'hF0
) (
    input  logic       g_clk,
    input  logic       g_clr,
    input  logic [3:0] irq_in,
    input  logic       mask_we,
    input  logic [3:0] mask_din,
    input  logic       clr_we,
    input  logic [3:0] clr_din,
    input  logic       itr_take,
    input  logic [7:0] pc_in,
    input  logic [7:0] acc_in,
    input  logic       rti,
    output logic       itr_pend,
    output logic [7:0] itr_vec,
    output logic [1:0] active_lvl,
    output logic       in_service,
    output logic       restore,
    output logic [3:0] itr_reg,
    output logic [3:0] mask_reg,
    output logic [7:0] pc_s_out,
    output logic [7:0] acc_s_out
);

    typedef enum logic [1:0] {StIdle, StPend, StService, StReturn} state_e;

    state_e     state_q, state_d;
    logic [3:0] s1_q, s2_q, prev_q;
    logic [3:0] itr_q, itr_d;
    logic [3:0] mask_q, mask_d;
    logic [7:0] pc_s_q, pc_s_d;
    logic [7:0] acc_s_q, acc_s_d;
    logic [7:0] vec_q, vec_d;
    logic [1:0] lvl_q, lvl_d;

    logic [3:0] edge_det;
    logic [3:0] eligible;
    logic [1:0] sel_lvl;
    logic       take_fire;

    assign edge_det = s2_q & ~prev_q;
    assign eligible = itr_q & mask_q;

    // Lowest set bit wins.
    always_comb begin
        sel_lvl = 2'd0;
        if (eligible[0]) begin
            sel_lvl = 2'd0;
        end else if (eligible[1]) begin
            sel_lvl = 2'd1;
        end else if (eligible[2]) begin
            sel_lvl = 2'd2;
        end else if (eligible[3]) begin
            sel_lvl = 2'd3;
        end
    end

    // A take only counts while something is still eligible; an empty PEND
    // falls back to IDLE instead.
    assign take_fire = (state_q == StPend) && (eligible != 4'd0) && itr_take;

    // Pending bits: an edge beats any clear so no event is lost.
    always_comb begin
        itr_d = itr_q;
        for (int i = 0; i < 4; i++) begin
            if (edge_det[i]) begin
                itr_d[i] = 1'b1;
            end else if (take_fire && (lvl_q == 2'(i))) begin
                itr_d[i] = 1'b0;
            end else if (clr_we && clr_din[i]) begin
                itr_d[i] = 1'b0;
            end
        end
    end

    assign mask_d  = mask_we ? mask_din : mask_q;
    assign pc_s_d  = take_fire ? pc_in : pc_s_q;
    assign acc_s_d = take_fire ? acc_in : acc_s_q;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (eligible != 4'd0) state_d = StPend;
            end
            StPend: begin
                if (eligible == 4'd0) begin
                    state_d = StIdle;
                end else if (itr_take) begin
                    state_d = StService;
                end
            end
            StService: begin
                if (rti) state_d = StReturn;
            end
            StReturn: begin
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Vector and level are registered against the next state. While offering,
    // they track sel_lvl; on take the offered level is held for the service.
    always_comb begin
        vec_d = 8'd0;
        lvl_d = 2'd0;
        if (state_d == StPend) begin
            vec_d = VEC_BASE + {4'b0000, sel_lvl, 2'b00};
            lvl_d = sel_lvl;
        end else if (state_d == StService || state_d == StReturn) begin
            lvl_d = lvl_q;
        end
    end

    always_ff @(posedge g_clk or posedge g_clr) begin
        if (g_clr) begin
            state_q <= StIdle;
            s1_q    <= 4'd0;
            s2_q    <= 4'd0;
            prev_q  <= 4'd0;
            itr_q   <= 4'd0;
            mask_q  <= 4'd0;
            pc_s_q  <= 8'd0;
            acc_s_q <= 8'd0;
            vec_q   <= 8'd0;
            lvl_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            s1_q    <= irq_in;
            s2_q    <= s1_q;
            prev_q  <= s2_q;
            itr_q   <= itr_d;
            mask_q  <= mask_d;
            pc_s_q  <= pc_s_d;
            acc_s_q <= acc_s_d;
            vec_q   <= vec_d;
            lvl_q   <= lvl_d;
        end
    end

    assign itr_pend   = (state_q == StPend);
    assign in_service = (state_q == StService);
    assign restore    = (state_q == StReturn);
    assign itr_vec    = vec_q;
    assign active_lvl = lvl_q;
    assign itr_reg    = itr_q;
    assign mask_reg   = mask_q;
    assign pc_s_out   = pc_s_q;
    assign acc_s_out  = acc_s_q;

endmodule

// File: tb/tb_itr_ctrl.sv
module tb_itr_ctrl;

    logic       g_clk;
    logic       g_clr;
    logic [3:0] irq_in;
    logic       mask_we;
    logic [3:0] mask_din;
    logic       clr_we;
    logic [3:0] clr_din;
    logic       itr_take;
    logic [7:0] pc_in;
    logic [7:0] acc_in;
    logic       rti;
    logic       itr_pend;
    logic [7:0] itr_vec;
    logic [1:0] active_lvl;
    logic       in_service;
    logic       restore;
    logic [3:0] itr_reg;
    logic [3:0] mask_reg;
    logic [7:0] pc_s_out;
    logic [7:0] acc_s_out;

    logic [36:0] all_outs;
    assign all_outs = {itr_pend, itr_vec, active_lvl, in_service, restore,
                       itr_reg, mask_reg, pc_s_out, acc_s_out};

    int vectors     = 0;
    int miscompares = 0;

    // Expected vectors, pushed when a request is driven, popped when offered.
    logic [7:0] exp_vec_q[$];

    itr_ctrl #(.VEC_BASE(8'hF0)) dut (
        .g_clk      (g_clk),
        .g_clr      (g_clr),
        .irq_in     (irq_in),
        .mask_we    (mask_we),
        .mask_din   (mask_din),
        .clr_we     (clr_we),
        .clr_din    (clr_din),
        .itr_take   (itr_take),
        .pc_in      (pc_in),
        .acc_in     (acc_in),
        .rti        (rti),
        .itr_pend   (itr_pend),
        .itr_vec    (itr_vec),
        .active_lvl (active_lvl),
        .in_service (in_service),
        .restore    (restore),
        .itr_reg    (itr_reg),
        .mask_reg   (mask_reg),
        .pc_s_out   (pc_s_out),
        .acc_s_out  (acc_s_out)
    );

    initial g_clk = 1'b0;
    always #5 g_clk = ~g_clk;

    task automatic tick(input int n);
        repeat (n) @(negedge g_clk);
    endtask

    task automatic set_mask(input logic [3:0] m);
        mask_we  = 1'b1;
        mask_din = m;
        tick(1);
        mask_we  = 1'b0;
    endtask

    task automatic do_take(input logic [7:0] pc, input logic [7:0] acc);
        itr_take = 1'b1;
        pc_in    = pc;
        acc_in   = acc;
        tick(1);
        itr_take = 1'b0;
    endtask

    task automatic do_rti();
        rti = 1'b1;
        tick(1);
        rti = 1'b0;
    endtask

    // Bounded wait for itr_pend; an expired budget is a miscompare.
    task automatic wait_pend(input int budget, input string tag);
        int n = 0;
        while (itr_pend !== 1'b1 && n < budget) begin
            tick(1);
            n++;
        end
        vectors++;
        if (itr_pend !== 1'b1) begin
            $display("FAIL %s: itr_pend=%b after %0d cycles, want 1", tag, itr_pend, budget);
            miscompares++;
        end
    endtask

    task automatic test_reset();
        logic [7:0] unused;
        unused = 8'd0;
        vectors++;
        if (all_outs !== 37'd0) begin
            $display("FAIL reset_outs: got %h, want 0", all_outs);
            miscompares++;
        end
        tick(1);
        g_clr = 1'b0;
        tick(3);
        vectors++;
        if (all_outs !== 37'd0) begin
            $display("FAIL post_reset_idle: got %h, want 0", all_outs);
            miscompares++;
        end
    endtask

    task automatic test_single();
        logic [7:0] exp;
        set_mask(4'b0100);
        irq_in[2] = 1'b1;
        exp_vec_q.push_back(8'hF8);
        tick(3);
        vectors++;
        if (itr_reg !== 4'b0100 || itr_pend !== 1'b0) begin
            $display("FAIL single_latch: itr_reg=%b pend=%b, want 0100/0", itr_reg, itr_pend);
            miscompares++;
        end
        tick(1);
        irq_in[2] = 1'b0;
        exp = exp_vec_q.pop_front();
        vectors++;
        if (itr_pend !== 1'b1 || itr_vec !== exp || active_lvl !== 2'd2) begin
            $display("FAIL single_offer: pend=%b vec=%h lvl=%0d, want 1/%h/2",
                     itr_pend, itr_vec, active_lvl, exp);
            miscompares++;
        end
        do_take(8'h3A, 8'h0A);
        vectors++;
        if (pc_s_out !== 8'h3A || acc_s_out !== 8'h0A || itr_reg !== 4'b0000
            || in_service !== 1'b1 || itr_pend !== 1'b0) begin
            $display("FAIL single_take: pc=%h acc=%h reg=%b svc=%b pend=%b, want 3A/0A/0000/1/0",
                     pc_s_out, acc_s_out, itr_reg, in_service, itr_pend);
            miscompares++;
        end
        do_rti();
        vectors++;
        if (restore !== 1'b1 || in_service !== 1'b0) begin
            $display("FAIL single_restore: restore=%b svc=%b, want 1/0", restore, in_service);
            miscompares++;
        end
        tick(1);
        vectors++;
        if (restore !== 1'b0 || itr_pend !== 1'b0 || pc_s_out !== 8'h3A) begin
            $display("FAIL single_idle: restore=%b pend=%b pc=%h, want 0/0/3A",
                     restore, itr_pend, pc_s_out);
            miscompares++;
        end
    endtask

    task automatic test_priority();
        logic [7:0] exp;
        set_mask(4'hF);
        irq_in = 4'b1010;
        exp_vec_q.push_back(8'hF4);
        exp_vec_q.push_back(8'hFC);
        wait_pend(10, "prio_first_pend");
        irq_in = 4'b0000;
        exp = exp_vec_q.pop_front();
        vectors++;
        if (itr_vec !== exp || active_lvl !== 2'd1) begin
            $display("FAIL prio_first_vec: vec=%h lvl=%0d, want %h/1", itr_vec, active_lvl, exp);
            miscompares++;
        end
        do_take(8'h11, 8'h22);
        tick(2);
        vectors++;
        if (itr_pend !== 1'b0 || in_service !== 1'b1 || itr_reg !== 4'b1000) begin
            $display("FAIL prio_no_nest: pend=%b svc=%b reg=%b, want 0/1/1000",
                     itr_pend, in_service, itr_reg);
            miscompares++;
        end
        do_rti();
        vectors++;
        if (restore !== 1'b1 || itr_pend !== 1'b0) begin
            $display("FAIL prio_restore: restore=%b pend=%b, want 1/0", restore, itr_pend);
            miscompares++;
        end
        tick(1);
        vectors++;
        if (restore !== 1'b0 || itr_pend !== 1'b0) begin
            $display("FAIL prio_gap: restore=%b pend=%b, want 0/0", restore, itr_pend);
            miscompares++;
        end
        tick(1);
        exp = exp_vec_q.pop_front();
        vectors++;
        if (itr_pend !== 1'b1 || itr_vec !== exp || active_lvl !== 2'd3) begin
            $display("FAIL prio_second: pend=%b vec=%h lvl=%0d, want 1/%h/3",
                     itr_pend, itr_vec, active_lvl, exp);
            miscompares++;
        end
        do_take(8'h33, 8'h44);
        do_rti();
        tick(3);
    endtask

    task automatic test_preempt();
        logic [7:0] exp;
        bit         dropped;
        int         n;
        irq_in[2] = 1'b1;
        exp_vec_q.push_back(8'hF8);
        wait_pend(10, "pre_first_pend");
        exp = exp_vec_q.pop_front();
        vectors++;
        if (itr_vec !== exp) begin
            $display("FAIL pre_first_vec: vec=%h, want %h", itr_vec, exp);
            miscompares++;
        end
        irq_in[0] = 1'b1;
        exp_vec_q.push_back(8'hF0);
        dropped = 1'b0;
        n = 0;
        while (itr_vec !== 8'hF0 && n < 10) begin
            tick(1);
            n++;
            if (itr_pend !== 1'b1) dropped = 1'b1;
        end
        exp = exp_vec_q.pop_front();
        vectors++;
        if (dropped || itr_vec !== exp || active_lvl !== 2'd0) begin
            $display("FAIL pre_switch: dropped=%b vec=%h lvl=%0d, want 0/%h/0",
                     dropped, itr_vec, active_lvl, exp);
            miscompares++;
        end
        irq_in = 4'b0000;
        do_take(8'h5A, 8'hA5);
        vectors++;
        if (in_service !== 1'b1 || itr_reg !== 4'b0100 || active_lvl !== 2'd0) begin
            $display("FAIL pre_take: svc=%b reg=%b lvl=%0d, want 1/0100/0",
                     in_service, itr_reg, active_lvl);
            miscompares++;
        end
        exp_vec_q.push_back(8'hF8);
        do_rti();
        tick(2);
        exp = exp_vec_q.pop_front();
        vectors++;
        if (itr_pend !== 1'b1 || itr_vec !== exp) begin
            $display("FAIL pre_resume: pend=%b vec=%h, want 1/%h", itr_pend, itr_vec, exp);
            miscompares++;
        end
        do_take(8'h00, 8'h00);
        do_rti();
        tick(3);
    endtask

    task automatic test_mask_clear();
        logic [7:0] exp;
        set_mask(4'b0000);
        irq_in[1] = 1'b1;
        tick(4);
        irq_in[1] = 1'b0;
        vectors++;
        if (itr_reg !== 4'b0010 || itr_pend !== 1'b0) begin
            $display("FAIL mask_hold: reg=%b pend=%b, want 0010/0", itr_reg, itr_pend);
            miscompares++;
        end
        exp_vec_q.push_back(8'hF4);
        set_mask(4'b0010);
        tick(1);
        exp = exp_vec_q.pop_front();
        vectors++;
        if (itr_pend !== 1'b1 || itr_vec !== exp) begin
            $display("FAIL mask_enable: pend=%b vec=%h, want 1/%h", itr_pend, itr_vec, exp);
            miscompares++;
        end
        clr_we  = 1'b1;
        clr_din = 4'b0010;
        tick(1);
        clr_we  = 1'b0;
        vectors++;
        if (itr_reg !== 4'b0000) begin
            $display("FAIL clr_reg: reg=%b, want 0000", itr_reg);
            miscompares++;
        end
        tick(1);
        vectors++;
        if (itr_pend !== 1'b0) begin
            $display("FAIL clr_drop: pend=%b, want 0", itr_pend);
            miscompares++;
        end
        tick(2);
    endtask

    task automatic test_edge_clear();
        set_mask(4'b0000);
        irq_in[3] = 1'b1;
        tick(2);
        // The edge reaches itr_reg on this next edge, together with the clear.
        clr_we  = 1'b1;
        clr_din = 4'b1000;
        tick(1);
        clr_we  = 1'b0;
        irq_in[3] = 1'b0;
        vectors++;
        if (itr_reg !== 4'b1000) begin
            $display("FAIL edge_beats_clr: reg=%b, want 1000", itr_reg);
            miscompares++;
        end
        clr_we  = 1'b1;
        tick(1);
        clr_we  = 1'b0;
        vectors++;
        if (itr_reg !== 4'b0000) begin
            $display("FAIL plain_clr: reg=%b, want 0000", itr_reg);
            miscompares++;
        end
        tick(2);
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp;
        set_mask(4'hF);
        irq_in[1] = 1'b1;
        exp_vec_q.push_back(8'hF4);
        wait_pend(10, "b2b_first_pend");
        irq_in[1] = 1'b0;
        exp = exp_vec_q.pop_front();
        vectors++;
        if (itr_vec !== exp) begin
            $display("FAIL b2b_first_vec: vec=%h, want %h", itr_vec, exp);
            miscompares++;
        end
        do_take(8'h77, 8'h88);
        irq_in[3] = 1'b1;
        exp_vec_q.push_back(8'hFC);
        tick(5);
        irq_in[3] = 1'b0;
        vectors++;
        if (itr_reg !== 4'b1000 || itr_pend !== 1'b0 || in_service !== 1'b1) begin
            $display("FAIL b2b_in_svc: reg=%b pend=%b svc=%b, want 1000/0/1",
                     itr_reg, itr_pend, in_service);
            miscompares++;
        end
        do_rti();
        vectors++;
        if (restore !== 1'b1 || itr_pend !== 1'b0) begin
            $display("FAIL b2b_restore: restore=%b pend=%b, want 1/0", restore, itr_pend);
            miscompares++;
        end
        tick(1);
        vectors++;
        if (itr_pend !== 1'b0) begin
            $display("FAIL b2b_gap: pend=%b, want 0", itr_pend);
            miscompares++;
        end
        tick(1);
        exp = exp_vec_q.pop_front();
        vectors++;
        if (itr_pend !== 1'b1 || itr_vec !== exp) begin
            $display("FAIL b2b_second: pend=%b vec=%h, want 1/%h", itr_pend, itr_vec, exp);
            miscompares++;
        end
        do_take(8'h99, 8'hAA);
        do_rti();
        tick(3);
    endtask

    task automatic test_reset_mid();
        bit saw_restore;
        irq_in[0] = 1'b1;
        wait_pend(10, "rst_pend");
        do_take(8'hC3, 8'h3C);
        vectors++;
        if (in_service !== 1'b1) begin
            $display("FAIL rst_pre_svc: svc=%b, want 1", in_service);
            miscompares++;
        end
        #2;
        g_clr = 1'b1;
        #1;
        vectors++;
        if (all_outs !== 37'd0) begin
            $display("FAIL rst_async: outs=%h, want 0", all_outs);
            miscompares++;
        end
        saw_restore = 1'b0;
        tick(1);
        if (restore !== 1'b0) saw_restore = 1'b1;
        g_clr = 1'b0;
        // irq_in[0] still high: one edge at release, latched but masked.
        for (int i = 0; i < 4; i++) begin
            tick(1);
            if (restore !== 1'b0) saw_restore = 1'b1;
        end
        vectors++;
        if (saw_restore || itr_reg !== 4'b0001 || itr_pend !== 1'b0 || mask_reg !== 4'b0000) begin
            $display("FAIL rst_release: restore_seen=%b reg=%b pend=%b mask=%b, want 0/0001/0/0000",
                     saw_restore, itr_reg, itr_pend, mask_reg);
            miscompares++;
        end
        do_rti();
        vectors++;
        if (restore !== 1'b0 || in_service !== 1'b0) begin
            $display("FAIL rst_rti_ignored: restore=%b svc=%b, want 0/0", restore, in_service);
            miscompares++;
        end
        do_take(8'h55, 8'h66);
        vectors++;
        if (pc_s_out !== 8'h00 || acc_s_out !== 8'h00 || in_service !== 1'b0) begin
            $display("FAIL rst_take_ignored: pc=%h acc=%h svc=%b, want 00/00/0",
                     pc_s_out, acc_s_out, in_service);
            miscompares++;
        end
        irq_in = 4'b0000;
    endtask

    initial begin
        g_clr    = 1'b1;
        irq_in   = 4'b0000;
        mask_we  = 1'b0;
        mask_din = 4'b0000;
        clr_we   = 1'b0;
        clr_din  = 4'b0000;
        itr_take = 1'b0;
        pc_in    = 8'h00;
        acc_in   = 8'h00;
        rti      = 1'b0;
        tick(2);
        test_reset();
        test_single();
        test_priority();
        test_preempt();
        test_mask_clear();
        test_edge_clear();
        test_back_to_back();
        test_reset_mid();
        vectors++;
        if (exp_vec_q.size() != 0) begin
            $display("FAIL scoreboard_drain: %0d left, want 0", exp_vec_q.size());
            miscompares++;
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Hard stop in case the stimulus itself stalls.
    initial begin
        #200000;
        $display("FAIL timeout: simulation still running at %0t, want finished", $time);
        $fatal(1);
    end

endmodule
